// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks [addr_lo..addr_hi] on one async read port
// and streams {addr,data} words over a valid/ready handshake.
module rf_dump_reader #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] addr_lo,
   input  logic [ADDR_WIDTH-1:0] addr_hi,
   output logic [ADDR_WIDTH-1:0] ra,
   input  logic [DATA_WIDTH-1:0] rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_hi;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_done;
   logic                  r_err;

   logic                  w_start_ok;
   logic                  w_start_bad;
   logic                  w_accept;
   logic                  w_last;

   assign w_start_ok  = (r_state == S_IDLE) && start && (addr_lo <= addr_hi);
   assign w_start_bad = (r_state == S_IDLE) && start && (addr_lo > addr_hi);
   assign w_accept    = r_out_valid && out_ready;
   // Compare before incrementing so the top address never needs a wrap.
   assign w_last      = (r_cnt == r_hi);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_start_ok) w_next = S_READ;
         S_READ: w_next = S_SEND;
         S_SEND: if (w_accept) w_next = w_last ? S_DONE : S_READ;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Combinational outputs: read address and busy flag
   always_comb begin
      ra   = (r_state == S_READ) ? r_cnt : '0;
      busy = (r_state == S_READ) || (r_state == S_SEND);
   end

   // Datapath: range capture, word capture, handshake and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_hi        <= '0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err  <= w_start_bad;
         r_done <= (r_state == S_SEND) && w_accept && w_last;
         unique case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_cnt <= addr_lo;
                  r_hi  <= addr_hi;
               end
            end
            S_READ: begin
               r_out_data  <= rd;
               r_out_addr  <= r_cnt;
               r_out_valid <= 1'b1;
            end
            S_SEND: begin
               if (w_accept) begin
                  r_out_valid <= 1'b0;
                  if (!w_last) r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: ;
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_addr  = r_out_addr;
   assign out_data  = r_out_data;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader with a behavioural register file.
module tb_rf_dump_reader;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] addr_lo;
   logic [AW-1:0] addr_hi;
   logic [AW-1:0] ra;
   logic [DW-1:0] rd;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          err;

   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic [DW-1:0] rf [32];

   int n_checks = 0;
   int n_errors = 0;

   rf_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
      .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Register file model: reset reloads rf[i] = i*0x11111111
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h11111111;
      end else if (we) begin
         rf[wa] <= wd;
      end
   end
   assign rd = rf[ra];

   typedef struct {
      int lo;
      int hi;
      int exp_err;
      int exp_words;
      int exp_done_k;
   } vec_t;

   vec_t vecs [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int a);
      return 32'(a) * 32'h11111111;
   endfunction

   // One dump with out_ready held high; done_k counts edges after the start edge
   task automatic run_dump(input int lo, input int hi, input int exp_err,
                           input int exp_words, input int exp_done_k, input int mid_start);
      int words  = 0;
      int dones  = 0;
      int done_k = -1;
      int errs   = 0;
      int valids = 0;
      out_ready = 1'b1;
      addr_lo   = AW'(lo);
      addr_hi   = AW'(hi);
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("err_after_start", err, 64'(exp_err));
      chk("busy_after_start", busy, 64'(exp_err == 0));
      for (int k = 1; k <= exp_done_k + 4; k++) begin
         step();
         start = 1'b0;
         if (err) errs++;
         if (done) begin
            dones++;
            done_k = k;
            chk("busy_at_done", busy, 0);
         end
         if (out_valid) valids++;
         if (out_valid && out_ready) begin
            chk("word_addr", out_addr, 64'(lo + words));
            chk("word_data", out_data, 64'(exp_data(lo + words)));
            words++;
         end
         if (mid_start != 0 && k == 2) begin
            start   = 1'b1;
            addr_lo = AW'(20);
            addr_hi = AW'(25);
         end
      end
      chk("word_count", 64'(words), 64'(exp_words));
      chk("done_count", 64'(dones), 64'(exp_err == 0));
      chk("done_latency", 64'(done_k), exp_err != 0 ? 64'(-1) : 64'(exp_done_k));
      chk("err_extra", 64'(errs), 0);
      if (exp_err != 0) chk("err_no_valid", 64'(valids), 0);
   endtask

   initial begin
      logic          done_seen;
      logic          prev_hold;
      logic          found;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      int            idx;

      vecs[0] = '{0, 31, 0, 32, 64};
      vecs[1] = '{5, 5, 0, 1, 2};
      vecs[2] = '{31, 31, 0, 1, 2};
      vecs[3] = '{10, 3, 1, 0, 0};
      vecs[4] = '{3, 4, 0, 2, 4};
      vecs[5] = '{30, 31, 0, 2, 4};
      vecs[6] = '{0, 0, 0, 1, 2};

      rst = 1'b1; start = 1'b0; addr_lo = '0; addr_hi = '0;
      out_ready = 1'b0; we = 1'b0; wa = '0; wd = '0;
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ra", ra, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 7; v++)
         run_dump(vecs[v].lo, vecs[v].hi, vecs[v].exp_err, vecs[v].exp_words, vecs[v].exp_done_k, 0);

      // Random backpressure over the full range
      addr_lo = '0; addr_hi = 5'd31; out_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      idx = 0; prev_hold = 1'b0; done_seen = 1'b0; pa = '0; pd = '0;
      for (int k = 0; k < 3000; k++) begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_addr", out_addr, 64'(pa));
            chk("hold_data", out_data, 64'(pd));
         end
         if (done) begin
            done_seen = 1'b1;
            break;
         end
         out_ready = ($urandom_range(0, 9) < 3);
         if (out_valid && out_ready) begin
            chk("rand_addr", out_addr, 64'(idx));
            chk("rand_data", out_data, 64'(exp_data(idx)));
            idx++;
         end
         prev_hold = out_valid && !out_ready;
         pa = out_addr;
         pd = out_data;
         step();
      end
      chk("rand_done_seen", done_seen, 1);
      chk("rand_word_count", 64'(idx), 32);
      out_ready = 1'b1;
      step();

      // Write to rf[7] on the capture edge: old value is streamed
      addr_lo = 5'd7; addr_hi = 5'd7; start = 1'b1;
      step();
      start = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
      step();
      we = 1'b0;
      chk("same_edge_valid", out_valid, 1);
      chk("same_edge_addr", out_addr, 7);
      chk("same_edge_data", out_data, 64'(32'h77777777));
      step(); step(); step();

      // Write one edge earlier (with start): new value is streamed
      we = 1'b1; wa = 5'd7; wd = 32'h77777777;
      step();
      wd = 32'hDEADBEEF; start = 1'b1;
      step();
      we = 1'b0; start = 1'b0;
      step();
      chk("early_write_valid", out_valid, 1);
      chk("early_write_data", out_data, 64'(32'hDEADBEEF));
      step(); step(); step();

      // Reset while streaming address 12
      addr_lo = '0; addr_hi = 5'd31; out_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (out_valid && out_addr == 5'd12) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("reach_addr12", found, 1);
      out_ready = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b1;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("abort_quiet", {done, out_valid, busy}, 0);
      end

      run_dump(0, 2, 0, 3, 6, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
